// File: rtl/router_pkg.sv
// Shared constants and types for the 1x3 router datapath.
package router_pkg;

   localparam int DEFAULT_DATA_WIDTH = 8;

   localparam logic [1:0] ADDR_P0      = 2'b00;
   localparam logic [1:0] ADDR_P1      = 2'b01;
   localparam logic [1:0] ADDR_P2      = 2'b10;
   localparam logic [1:0] ADDR_INVALID = 2'b11;

   // One-hot state strobes from the router FSM.
   typedef struct packed {
      logic detect_add;
      logic lfd_state;
      logic ld_state;
      logic laf_state;
      logic full_state;
   } strobe_t;

   function automatic logic addr_valid(input logic [1:0] addr);
      return addr != ADDR_INVALID;
   endfunction

endpackage

// File: rtl/router_parity_chk.sv
// Running XOR parity of header and payload, captured parity byte, and the
// parity_done / err flags that report the result back to the FSM and host.
module router_parity_chk
   import router_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
   input  logic                  clock,
   input  logic                  resetn,
   input  strobe_t               strobes,
   input  logic                  pkt_valid,
   input  logic                  fifo_full,
   input  logic                  low_pkt_valid,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic [DATA_WIDTH-1:0] hdr_byte,
   output logic                  parity_done,
   output logic                  err
);

   logic [DATA_WIDTH-1:0] int_parity;
   logic [DATA_WIDTH-1:0] pkt_parity;

   // A stalled byte is folded in while still in LOAD_DATA, so FIFO_FULL and
   // LOAD_AFTER_FULL must not touch the accumulator again.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         int_parity <= '0;
      end else if (strobes.detect_add) begin
         int_parity <= '0;
      end else if (strobes.lfd_state) begin
         int_parity <= int_parity ^ hdr_byte;
      end else if (strobes.ld_state && pkt_valid && !strobes.full_state) begin
         int_parity <= int_parity ^ data_in;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         pkt_parity <= '0;
      end else if (strobes.detect_add) begin
         pkt_parity <= '0;
      end else if (strobes.ld_state && !pkt_valid) begin
         pkt_parity <= data_in;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         parity_done <= 1'b0;
      end else if (strobes.detect_add) begin
         parity_done <= 1'b0;
      end else if ((strobes.ld_state && !pkt_valid && !fifo_full) ||
                   (strobes.laf_state && low_pkt_valid && !parity_done)) begin
         parity_done <= 1'b1;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         err <= 1'b0;
      end else if (strobes.detect_add) begin
         err <= 1'b0;
      end else if (parity_done && (pkt_parity != int_parity)) begin
         err <= 1'b1;
      end
   end

endmodule

// File: rtl/router_reg.sv
// Router datapath register stage: header latch, FIFO write data mux, stalled
// byte holding register and low_pkt_valid flag; parity lives in the sub-module.
module router_reg
   import router_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
   input  logic                  clock,
   input  logic                  resetn,
   input  logic                  pkt_valid,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  fifo_full,
   input  logic                  detect_add,
   input  logic                  lfd_state,
   input  logic                  ld_state,
   input  logic                  laf_state,
   input  logic                  full_state,
   input  logic                  rst_int_reg,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  parity_done,
   output logic                  low_pkt_valid,
   output logic                  err
);

   strobe_t               strobes;
   logic [DATA_WIDTH-1:0] hdr_byte;
   logic [DATA_WIDTH-1:0] full_byte;

   assign strobes = '{detect_add: detect_add, lfd_state: lfd_state, ld_state: ld_state,
                      laf_state: laf_state, full_state: full_state};

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         hdr_byte <= '0;
      end else if (detect_add && pkt_valid && addr_valid(data_in[1:0])) begin
         hdr_byte <= data_in;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         full_byte <= '0;
      end else if (ld_state && fifo_full) begin
         full_byte <= data_in;
      end
   end

   // A byte that meets a full FIFO leaves dout untouched; it is replayed from full_byte.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         dout <= '0;
      end else if (lfd_state) begin
         dout <= hdr_byte;
      end else if (ld_state && !fifo_full) begin
         dout <= data_in;
      end else if (laf_state) begin
         dout <= full_byte;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         low_pkt_valid <= 1'b0;
      end else if (rst_int_reg) begin
         low_pkt_valid <= 1'b0;
      end else if (ld_state && !pkt_valid) begin
         low_pkt_valid <= 1'b1;
      end
   end

   router_parity_chk #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_parity (
      .clock         (clock),
      .resetn        (resetn),
      .strobes       (strobes),
      .pkt_valid     (pkt_valid),
      .fifo_full     (fifo_full),
      .low_pkt_valid (low_pkt_valid),
      .data_in       (data_in),
      .hdr_byte      (hdr_byte),
      .parity_done   (parity_done),
      .err           (err)
   );

endmodule
